cnn_conv_engine: RTL and testbench

CNN_CONV_ENGINE -- requirements
Module: cnn_conv_engine

---
 rtl/cnn_conv_engine.sv | 170 +++++++++++++++++
 tb/tb_cnn_conv_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : cnn_conv_engine
// Description : Streaming dot-product engine for one CNN kernel window.
//               TAPS signed coefficients are loaded while idle. Each window
//               multiplies TAPS unsigned pixels by the stored coefficients and
//               sums the products. The sum then gets optional ReLU, is
//               saturated to OUT_W and is held until the consumer accepts it.
//               Continuous mode restarts the next window automatically.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_conv_engine #(
    parameter int DATA_W  = 4,
    parameter int COEF_W  = 4,
    parameter int TAPS    = 9,
    parameter int ACC_W   = 13,
    parameter int OUT_W   = 10,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_wr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              start,
    input  logic              cont,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              res_valid,
    output logic [OUT_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    localparam int c_tw = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int c_pw = DATA_W + COEF_W + 1;
    localparam logic [c_tw-1:0] c_last = c_tw'(TAPS - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_accum = 2'd1;
    localparam logic [1:0] c_out   = 2'd2;

    localparam logic signed [ACC_W-1:0] c_res_max = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_res_min = ACC_W'(-(2 ** (OUT_W - 1)));

    logic [1:0]               r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [c_tw-1:0]          r_tap;
    logic [c_tw-1:0]          r_ptr;
    logic                     r_cont;
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic                     r_pix_ready;
    logic                     r_res_valid;
    logic [OUT_W-1:0]         r_res_data;
    logic                     r_busy;
    logic                     r_done;

    logic signed [c_pw-1:0]   w_pix_x;
    logic signed [c_pw-1:0]   w_coef_x;
    logic signed [c_pw-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic [OUT_W-1:0]         w_res;

    // Pixel is zero-extended so the multiply stays signed; both operands
    // are widened to the full product width before multiplying.
    assign w_pix_x  = c_pw'($signed({1'b0, pix_data}));
    assign w_coef_x = c_pw'(r_coef[r_tap]);
    assign w_prod   = w_pix_x * w_coef_x;
    assign w_sum    = r_acc + ACC_W'(w_prod);

    // Result formatting of the running sum: optional ReLU, then saturation.
    always_comb begin
        w_res = w_sum[OUT_W-1:0];
        if ((RELU_EN != 0) && w_sum[ACC_W-1]) begin
            w_res = '0;
        end else if (w_sum > c_res_max) begin
            w_res = c_res_max[OUT_W-1:0];
        end else if (w_sum < c_res_min) begin
            w_res = c_res_min[OUT_W-1:0];
        end
    end

    // Coefficient store and write pointer; writable only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coef_wr && (r_state == c_idle)) begin
            r_coef[r_ptr] <= $signed(coef_data);
            r_ptr         <= (r_ptr == c_last) ? '0 : r_ptr + c_tw'(1);
        end
    end

    // Window sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_acc       <= '0;
            r_tap       <= '0;
            r_cont      <= 1'b0;
            r_pix_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state     <= c_accum;
                        r_acc       <= '0;
                        r_tap       <= '0;
                        r_cont      <= cont;
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                c_accum: begin
                    if (pix_valid) begin
                        r_acc <= w_sum;
                        if (r_tap == c_last) begin
                            // Tap returns to 0 so the coefficient read never
                            // indexes past the store.
                            r_tap       <= '0;
                            r_state     <= c_out;
                            r_res_data  <= w_res;
                            r_res_valid <= 1'b1;
                            r_pix_ready <= 1'b0;
                        end else begin
                            r_tap <= r_tap + c_tw'(1);
                        end
                    end
                end
                c_out: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_cont) begin
                            r_state     <= c_accum;
                            r_acc       <= '0;
                            r_tap       <= '0;
                            r_pix_ready <= 1'b1;
                        end else begin
                            r_state <= c_idle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= c_idle;
                    r_pix_ready <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready = r_pix_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_conv_engine
// Description : Self-checking bench for cnn_conv_engine. Two instances share
//               stimulus: one with ReLU enabled, one without. Expected results
//               are queued when a window is driven and compared on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_conv_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       coef_wr;
    logic [3:0] coef_data;
    logic       start;
    logic       cont;
    logic       pix_valid;
    logic [3:0] pix_data;
    logic       res_ready;
    logic       pix_ready,    res_valid,    busy,    done;
    logic [9:0] res_data;
    logic       pix_ready_nr, res_valid_nr, busy_nr, done_nr;
    logic [9:0] res_data_nr;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        int exp_r;
        int exp_nr;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int coef;
        int pix0;
        int pinc;
        int gaps;
        int hold;
        int same;
        int exp_r;
        int exp_nr;
    } vec_t;
    vec_t tbl[8];

    int coef_v[9];

    always #5 clk = ~clk;

    cnn_conv_engine u_dut (
        .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_data(coef_data),
        .start(start), .cont(cont), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    cnn_conv_engine #(.RELU_EN(0)) u_dut_nr (
        .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_data(coef_data),
        .start(start), .cont(cont), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready_nr), .res_valid(res_valid_nr), .res_data(res_data_nr),
        .res_ready(res_ready), .busy(busy_nr), .done(done_nr)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop one expectation at every result handshake.
    always @(negedge clk) begin
        if (!rst && done) done_cnt++;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0d required=empty_queue", $signed(res_data));
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("res_data", $signed(res_data), e.exp_r);
                check("res_data_nr", $signed(res_data_nr), e.exp_nr);
                check("res_valid_nr", res_valid_nr, 1);
            end
        end
    end

    task automatic load_and_start(input bit same, input bit c);
        for (int k = 0; k < 9; k++) begin
            coef_wr   = 1'b1;
            coef_data = 4'(coef_v[k]);
            if (k == 8 && same) begin
                start = 1'b1;
                cont  = c;
            end
            tick();
        end
        coef_wr = 1'b0;
        if (!same) begin
            start = 1'b1;
            cont  = c;
            tick();
        end
        start = 1'b0;
        cont  = 1'b0;
        check("start_busy", busy, 1);
        check("start_pix_ready", pix_ready, 1);
    endtask

    task automatic stream(input int pix0, input int pinc, input bit gaps, input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            if (gaps) begin
                pix_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            pix_valid = 1'b1;
            pix_data  = 4'(pix0 + pinc * k);
            w = 0;
            while (!pix_ready && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) check("pix_ready_timeout", w, 0);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic finish_result(input int hold, input int exp_r, input bit exp_done);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("bp_hold_data", $signed(res_data), exp_r);
            check("bp_hold_valid", res_valid, 1);
            check("bp_pix_ready", pix_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if (exp_done) begin
            check("done_pulse", done, 1);
            check("busy_after", busy, 0);
            tick();
            check("done_once", done, 0);
        end else begin
            check("cont_no_done", done, 0);
            check("cont_busy", busy, 1);
            check("cont_pix_ready", pix_ready, 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt0;
        // coef, pix0, pinc, gaps, hold, same, exp_relu, exp_norelu
        tbl[0] = '{ 1,  1, 1, 0, 0, 0,  45,   45};
        tbl[1] = '{-8, 15, 0, 0, 5, 0,   0, -512};
        tbl[2] = '{ 7, 15, 0, 1, 0, 0, 511,  511};
        tbl[3] = '{-1,  1, 1, 1, 2, 1,   0,  -45};
        tbl[4] = '{ 3,  0, 1, 0, 0, 1, 108,  108};
        tbl[5] = '{ 0, 15, 0, 0, 0, 0,   0,    0};
        tbl[6] = '{ 7,  8, 0, 1, 0, 0, 504,  504};
        tbl[7] = '{-7,  8, 0, 0, 1, 0,   0, -504};

        rst = 1'b1; coef_wr = 1'b0; coef_data = '0; start = 1'b0; cont = 1'b0;
        pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst_outs", {pix_ready, res_valid, busy, done}, 0);
        check("rst_res_data", res_data, 0);
        check("rst_outs_nr", {pix_ready_nr, res_valid_nr, busy_nr, done_nr}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 9; k++) coef_v[k] = tbl[i].coef;
            sb_q.push_back('{tbl[i].exp_r, tbl[i].exp_nr});
            load_and_start(tbl[i].same != 0, 1'b0);
            stream(tbl[i].pix0, tbl[i].pinc, tbl[i].gaps != 0, 9);
            check("res_valid_latency", res_valid, 1);
            check("pix_ready_in_out", pix_ready, 0);
            finish_result(tbl[i].hold, tbl[i].exp_r, 1'b1);
        end

        // Continuous mode with distinct coefficients, two windows.
        coef_v = '{1, -1, 2, -2, 3, -3, 4, -4, 5};
        dcnt0 = done_cnt;
        sb_q.push_back('{35, 35});
        load_and_start(1'b0, 1'b1);
        stream(1, 1, 1'b0, 9);
        check("cont_lat_a", res_valid, 1);
        finish_result(3, 35, 1'b0);
        // start and coef_wr while running must both be ignored.
        start = 1'b1; coef_wr = 1'b1; coef_data = 4'd7;
        tick();
        start = 1'b0; coef_wr = 1'b0;
        sb_q.push_back('{10, 10});
        stream(2, 0, 1'b1, 9);
        check("cont_lat_b", res_valid, 1);
        finish_result(0, 10, 1'b0);
        check("cont_done_count", done_cnt - dcnt0, 0);

        // Reset after four accepts of a third continuous window.
        stream(3, 1, 1'b0, 4);
        rst = 1'b1;
        tick();
        check("midrst_outs", {pix_ready, res_valid, busy, done}, 0);
        check("midrst_res_data", res_data, 0);
        rst = 1'b0;
        tick();
        check("midrst_idle_ready", pix_ready, 0);

        // Coefficients were cleared: a window without reload yields 0.
        sb_q.push_back('{0, 0});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_busy", busy, 1);
        stream(15, 0, 1'b0, 9);
        check("post_rst_lat", res_valid, 1);
        finish_result(0, 0, 1'b1);

        repeat (3) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
